// File: rtl/axil_ctrl_pkg.sv
// Shared constants and FSM encoding for the AXI4-Lite control register block.
package axil_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int REG_CTRL     = 0;
  localparam int REG_PULSE    = 1;
  localparam int REG_STATUS   = 2;
  localparam int REG_SCRATCH0 = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WA,
    ST_WD,
    ST_WR,
    ST_BR,
    ST_RD
  } state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage for the control block: CTRL, PULSE, SCRATCH words with WSTRB byte merge and a read mux.
module axil_reg_bank
  import axil_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 10,
  parameter int NUM_REGS = 8,
  parameter int CTRL_W   = 3,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  localparam int STRB_W  = DATA_W / 8,
  localparam int NUM_SCR = NUM_REGS - REG_SCRATCH0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [STRB_W-1:0]         wr_strb,
  input  logic [IDX_W-1:0]          rd_idx,
  input  logic [DATA_W-1:0]         status_i,
  output logic [DATA_W-1:0]         rd_data,
  output logic [CTRL_W-1:0]         ctrl_o,
  output logic [DATA_W-1:0]         pulse_o,
  output logic [NUM_SCR*DATA_W-1:0] scratch_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] scratch_q [NUM_SCR];
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] ctrl_wide;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_mask = '0;
    for (int b = 0; b < STRB_W; b++) wr_mask[8*b +: 8] = {8{wr_strb[b]}};
  end

  assign ctrl_wide = DATA_W'(ctrl_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_RST;
      pulse_o <= '0;
      // NOTE: scratch words are software-visible state with a defined reset value, so this array is
      // reset explicitly rather than inferred as RAM.
      for (int i = 0; i < NUM_SCR; i++) scratch_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      pulse_o <= '0;
      if (wr_en) begin
        if (wr_idx == IDX_W'(REG_CTRL))
          ctrl_q <= CTRL_W'((ctrl_wide & ~wr_mask) | (wr_data & wr_mask));
        if (wr_idx == IDX_W'(REG_PULSE))
          pulse_o <= wr_data & wr_mask;
        for (int i = 0; i < NUM_SCR; i++)
          if (wr_idx == IDX_W'(REG_SCRATCH0 + i))
            scratch_q[i] <= (scratch_q[i] & ~wr_mask) | (wr_data & wr_mask);
      end
    end
  end

  // PULSE reads as zero; STATUS is the live input, captured by the caller on the AR handshake.
  always_comb begin
    rd_data = '0;
    if (rd_idx == IDX_W'(REG_CTRL))   rd_data = ctrl_wide;
    if (rd_idx == IDX_W'(REG_STATUS)) rd_data = status_i;
    for (int i = 0; i < NUM_SCR; i++)
      if (rd_idx == IDX_W'(REG_SCRATCH0 + i)) rd_data = scratch_q[i];
  end

  assign ctrl_o = ctrl_q;

  for (genvar g = 0; g < NUM_SCR; g++) begin : g_scr
    assign scratch_o[g*DATA_W +: DATA_W] = scratch_q[g];
  end

endmodule

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite slave front end: handshake FSM, read/write fairness and address decode around axil_reg_bank.
module axil_ctrl_regs
  import axil_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int NUM_REGS = 8,
  parameter int CTRL_W   = 3,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]                  S_AXI_AWADDR,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [DATA_W-1:0]                  S_AXI_WDATA,
  input  logic [STRB_W-1:0]                  S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [ADDR_W-1:0]                  S_AXI_ARADDR,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [DATA_W-1:0]                  S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [CTRL_W-1:0]                  ctrl_o,
  output logic [DATA_W-1:0]                  pulse_o,
  input  logic [DATA_W-1:0]                  status_i,
  output logic [(NUM_REGS-3)*DATA_W-1:0]     scratch_o
);

  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;

  state_t              state;
  logic                live;
  logic                prefer_wr;
  logic [IDX_W-1:0]    aw_idx;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic [DATA_W-1:0]   bank_rd_data;
  logic                idle, wr_req, rd_wins;
  logic                aw_hs, w_hs, ar_hs, wr_en;
  logic [IDX_W-1:0]    aw_idx_in, ar_idx;
  logic                unused_addr_lsbs;

  function automatic logic [1:0] resp_for(input logic [IDX_W-1:0] idx, input logic is_wr);
    if (idx >= IDX_W'(NUM_REGS))                 return RESP_DECERR;
    if (is_wr && (idx == IDX_W'(REG_STATUS)))    return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  assign aw_idx_in        = S_AXI_AWADDR[ADDR_W-1:ADDR_LSB];
  assign ar_idx           = S_AXI_ARADDR[ADDR_W-1:ADDR_LSB];
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Readies stay low until the first clock after reset release; in IDLE a contested
  // request goes to whichever side was not served last.
  assign idle          = live && (state == ST_IDLE);
  assign wr_req        = S_AXI_AWVALID | S_AXI_WVALID;
  assign rd_wins       = S_AXI_ARVALID & ~(wr_req & prefer_wr);
  assign S_AXI_AWREADY = (idle & ~rd_wins) | (state == ST_WD);
  assign S_AXI_WREADY  = (idle & ~rd_wins) | (state == ST_WA);
  assign S_AXI_ARREADY = idle & ~(wr_req & prefer_wr);

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign wr_en = (state == ST_WR) && (aw_idx < IDX_W'(NUM_REGS));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state        <= ST_IDLE;
      live         <= 1'b0;
      prefer_wr    <= 1'b1;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      live <= 1'b1;
      if (aw_hs) aw_idx <= aw_idx_in;
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      case (state)
        ST_IDLE: begin
          if (aw_hs || w_hs) begin
            prefer_wr <= 1'b0;
            state     <= (aw_hs && w_hs) ? ST_WR : (aw_hs ? ST_WA : ST_WD);
          end else if (ar_hs) begin
            prefer_wr    <= 1'b1;
            state        <= ST_RD;
            S_AXI_RDATA  <= bank_rd_data;
            S_AXI_RRESP  <= resp_for(ar_idx, 1'b0);
            S_AXI_RVALID <= 1'b1;
          end
        end
        ST_WA: if (w_hs)  state <= ST_WR;
        ST_WD: if (aw_hs) state <= ST_WR;
        ST_WR: begin
          state        <= ST_BR;
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP  <= resp_for(aw_idx, 1'b1);
        end
        ST_BR: if (S_AXI_BREADY) begin
          S_AXI_BVALID <= 1'b0;
          state        <= ST_IDLE;
        end
        ST_RD: if (S_AXI_RREADY) begin
          S_AXI_RVALID <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axil_reg_bank #(
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS),
    .CTRL_W   (CTRL_W),
    .CTRL_RST (CTRL_RST)
  ) u_bank (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .wr_en     (wr_en),
    .wr_idx    (aw_idx),
    .wr_data   (w_data),
    .wr_strb   (w_strb),
    .rd_idx    (ar_idx),
    .status_i  (status_i),
    .rd_data   (bank_rd_data),
    .ctrl_o    (ctrl_o),
    .pulse_o   (pulse_o),
    .scratch_o (scratch_o)
  );

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Self-checking bench for axil_ctrl_regs: directed AXI-Lite traffic against a behavioural register model.
module tb_axil_ctrl_regs;

  localparam int DATA_W = 32, ADDR_W = 12, NUM_REGS = 8, CTRL_W = 3, NSCR = NUM_REGS - 3;

  logic                   S_AXI_ACLK = 1'b0;
  logic                   S_AXI_ARESETN;
  logic [ADDR_W-1:0]      S_AXI_AWADDR, S_AXI_ARADDR;
  logic                   S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [DATA_W-1:0]      S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]             S_AXI_WSTRB;
  logic [1:0]             S_AXI_BRESP, S_AXI_RRESP;
  logic                   S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic                   S_AXI_RVALID, S_AXI_RREADY;
  logic [CTRL_W-1:0]      ctrl_o;
  logic [DATA_W-1:0]      pulse_o, status_i;
  logic [NSCR*DATA_W-1:0] scratch_o;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  axil_ctrl_regs #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .CTRL_W(CTRL_W), .CTRL_RST(3'b000)
  ) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ctrl_o(ctrl_o), .pulse_o(pulse_o), .status_i(status_i), .scratch_o(scratch_o)
  );

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents as the master should see them.
  logic [31:0] m_ctrl, m_pulse, m_rdata;
  logic [31:0] m_scr [NSCR];
  logic [1:0]  m_bresp, m_rresp;
  bit          cmp_en = 0;

  logic [31:0] last_pulse, last_rdata;
  logic [1:0]  last_bresp, last_rresp;
  int          wr_lat, pulse_cycles;
  int          order_q [$];

  function automatic logic [31:0] smask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [1:0] exp_resp(input int idx, input bit is_wr);
    if (idx >= NUM_REGS) return 2'b11;
    if (is_wr && idx == 2) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_read(input int idx, input logic [31:0] st);
    if (idx == 0) return m_ctrl;
    if (idx == 2) return st;
    if (idx >= 3 && idx < NUM_REGS) return m_scr[idx-3];
    return 32'h0;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mk;
    mk = smask(s);
    if (idx == 0)                         m_ctrl = ((m_ctrl & ~mk) | (d & mk)) & 32'h7;
    else if (idx == 1)                    m_pulse = d & mk;
    else if (idx >= 3 && idx < NUM_REGS)  m_scr[idx-3] = (m_scr[idx-3] & ~mk) | (d & mk);
  endtask

  // Compare process: outputs against the model on every cycle out of reset.
  always @(negedge S_AXI_ACLK) begin
    if (S_AXI_ARESETN && cmp_en) begin
      check("ctrl_o", ctrl_o, m_ctrl);
      check("pulse_o", pulse_o, m_pulse);
      for (int i = 0; i < NSCR; i++) check($sformatf("scratch%0d", i), scratch_o[i*32 +: 32], m_scr[i]);
      if (S_AXI_BVALID) check("bresp", S_AXI_BRESP, m_bresp);
      if (S_AXI_RVALID) begin
        check("rdata", S_AXI_RDATA, m_rdata);
        check("rresp", S_AXI_RRESP, m_rresp);
      end
    end
  end

  always @(negedge S_AXI_ACLK) if (S_AXI_ARESETN && pulse_o != '0) pulse_cycles++;

  task automatic do_reset();
    cmp_en = 0;
    S_AXI_ARESETN = 1'b0;
    {S_AXI_AWVALID, S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_RREADY} = '0;
    S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; status_i = '0;
    m_ctrl = '0; m_pulse = '0; m_rdata = '0; m_bresp = '0; m_rresp = '0;
    for (int i = 0; i < NSCR; i++) m_scr[i] = '0;
    repeat (2) @(posedge S_AXI_ACLK);
    @(negedge S_AXI_ACLK);
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_wready", S_AXI_WREADY, 0);
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_rvalid", S_AXI_RVALID, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    check("rst_ctrl", ctrl_o, 0);
    check("rst_pulse", pulse_o, 0);
    check("rst_scratch", scratch_o[63:0], 0);
    S_AXI_ARESETN = 1'b1;
    @(posedge S_AXI_ACLK); #1;
    cmp_en = 1;
  endtask

  // One write and/or one read, run concurrently; called and returns at posedge+1.
  task automatic run_txn(input bit do_wr, input logic [11:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int aw_dly, input int w_dly, input int b_dly,
                         input bit do_rd, input logic [11:0] raddr);
    bit aw_done, w_done, wr_seen, b_done, ar_done, r_done;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int b_first, r_first, hs_cyc, c;
    logic [31:0] st_now;
    aw_done = 0; w_done = 0; wr_seen = 0; ar_done = 0;
    b_done = !do_wr; r_done = !do_rd;
    b_first = -1; r_first = -1; hs_cyc = -1; c = 0;
    S_AXI_AWADDR = waddr; S_AXI_WDATA = wdata; S_AXI_WSTRB = wstrb; S_AXI_ARADDR = raddr;
    while (!(b_done && r_done) && c < 100) begin
      S_AXI_AWVALID = do_wr && !aw_done && c >= aw_dly;
      S_AXI_WVALID  = do_wr && !w_done && c >= w_dly;
      S_AXI_BREADY  = b_first >= 0 && (c - b_first) >= b_dly;
      S_AXI_ARVALID = do_rd && !ar_done;
      S_AXI_RREADY  = r_first >= 0;
      @(negedge S_AXI_ACLK);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      b_hs  = S_AXI_BVALID && S_AXI_BREADY;
      ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
      r_hs  = S_AXI_RVALID && S_AXI_RREADY;
      if (b_first >= 0 && !b_done) begin
        check("bvalid_hold", S_AXI_BVALID, 1);
        if (do_rd && !ar_done) check("ar_blocked", S_AXI_ARREADY, 0);
      end
      st_now = status_i;
      @(posedge S_AXI_ACLK); #1;
      c++;
      m_pulse = '0;
      if ((aw_hs || w_hs) && !wr_seen) begin wr_seen = 1; order_q.push_back(1); end
      aw_done |= aw_hs;
      w_done  |= w_hs;
      if (aw_done && w_done && hs_cyc < 0) begin
        hs_cyc  = c - 1;
        m_bresp = exp_resp(int'(waddr >> 2), 1);
      end
      if (ar_hs) begin
        ar_done = 1;
        order_q.push_back(0);
        m_rdata = exp_read(int'(raddr >> 2), st_now);
        m_rresp = exp_resp(int'(raddr >> 2), 0);
        status_i = '0;
      end
      if (b_hs) b_done = 1;
      else if (do_wr && S_AXI_BVALID && b_first < 0) begin
        b_first = c; wr_lat = c - hs_cyc;
        last_bresp = S_AXI_BRESP; last_pulse = pulse_o;
        model_write(int'(waddr >> 2), wdata, wstrb);
      end
      if (r_hs) r_done = 1;
      else if (do_rd && S_AXI_RVALID && r_first < 0) begin
        r_first = c; last_rdata = S_AXI_RDATA; last_rresp = S_AXI_RRESP;
      end
    end
    {S_AXI_AWVALID, S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_RREADY} = '0;
    check("txn_done", b_done && r_done, 1);
    if (do_wr) check("wr_latency", wr_lat, 2);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    run_txn(1, a, d, s, 0, 0, 0, 0, 12'h0);
  endtask

  task automatic rd(input logic [11:0] a);
    run_txn(0, 12'h0, 32'h0, 4'h0, 0, 0, 0, 1, a);
  endtask

  initial begin
    int ord;
    do_reset();

    wr(12'h000, 32'h5, 4'hF);
    check("ctrl_after_wr", ctrl_o, 3'b101);
    check("ctrl_bresp", last_bresp, 2'b00);

    run_txn(1, 12'h00C, 32'hAABBCCDD, 4'b0010, 3, 0, 0, 0, 12'h0);
    check("scr0_strb", scratch_o[31:0], 32'h0000CC00);

    pulse_cycles = 0;
    wr(12'h004, 32'h6, 4'hF);
    repeat (2) @(posedge S_AXI_ACLK); #1;
    check("pulse_value", last_pulse, 32'h6);
    check("pulse_cycles", pulse_cycles, 1);
    rd(12'h004);
    check("pulse_read", last_rdata, 32'h0);
    check("pulse_rresp", last_rresp, 2'b00);

    status_i = 32'h1234;
    rd(12'h008);
    check("status_read", last_rdata, 32'h1234);
    wr(12'h008, 32'hFFFF, 4'hF);
    check("status_bresp", last_bresp, 2'b10);

    wr(12'h020, 32'hFFFFFFFF, 4'hF);
    check("decerr_bresp", last_bresp, 2'b11);
    check("decerr_ctrl", ctrl_o, 3'b101);
    rd(12'h020);
    check("decerr_rdata", last_rdata, 32'h0);
    check("decerr_rresp", last_rresp, 2'b11);

    pulse_cycles = 0;
    wr(12'h010, 32'hDEADBEEF, 4'h0);
    check("strb0_bresp", last_bresp, 2'b00);
    wr(12'h004, 32'hDEADBEEF, 4'h0);
    repeat (2) @(posedge S_AXI_ACLK); #1;
    check("strb0_pulse", pulse_cycles, 0);
    check("strb0_scr1", scratch_o[63:32], 32'h0);
    rd(12'h00C);
    check("scr0_read", last_rdata, 32'h0000CC00);
    rd(12'h000);
    check("ctrl_read", last_rdata, 32'h5);

    do_reset();
    order_q.delete();
    run_txn(1, 12'h014, 32'h11, 4'hF, 0, 0, 5, 1, 12'h000);
    run_txn(1, 12'h018, 32'h22, 4'hF, 0, 0, 0, 1, 12'h014);
    check("read_after_fair", last_rdata, 32'h11);
    ord = 0;
    foreach (order_q[i]) ord = ord * 2 + order_q[i];
    check("order_len", order_q.size(), 4);
    check("order_seq", ord, 4'b1010);

    repeat (2) @(posedge S_AXI_ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
